// File: rtl/pll_dri_pkg.sv
// Shared types and constants for the PF_CCC PLL DRI initiator.
package pll_dri_pkg;

    localparam int ADDR_W  = 9;
    localparam int DATA_W  = 33;
    localparam int CTRL_W  = ADDR_W + 2;
    localparam int CTRL_WR = 10;
    localparam int CTRL_RD = 9;

    typedef enum logic [1:0] {
        OP_RD   = 2'b00,
        OP_WR   = 2'b01,
        OP_RMW  = 2'b10,
        OP_RSVD = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        ST_INIT,
        ST_IDLE,
        ST_RD_ISSUE,
        ST_RD_WAIT,
        ST_WR_ISSUE,
        ST_WR_WAIT,
        ST_RELOCK,
        ST_RESP
    } state_e;

    // Frequently accessed PLL registers
    localparam logic [ADDR_W-1:0] REG_DIV0_CTRL = 9'h005;
    localparam logic [ADDR_W-1:0] REG_DIV1_CTRL = 9'h006;

    function automatic logic [CTRL_W-1:0] dri_ctrl(input logic wr, input logic rd,
                                                   input logic [ADDR_W-1:0] addr);
        logic [CTRL_W-1:0] c;
        c                = '0;
        c[CTRL_WR]       = wr;
        c[CTRL_RD]       = rd;
        c[ADDR_W-1:0]    = addr;
        return c;
    endfunction

endpackage

// File: rtl/pll_dri_master_if.sv
// Request/response port plus the DRI pins of the PLL, bundled for pll_dri_master.
// PLL_LOCK joins the master modport only in the PLL_DRI_RELOCK_WAIT_EN build.
interface pll_dri_master_if;
    import pll_dri_pkg::*;

    logic              REQ_VALID;
    logic              REQ_READY;
    logic [1:0]        REQ_OP;
    logic [ADDR_W-1:0] REQ_ADDR;
    logic [DATA_W-1:0] REQ_WDATA;
    logic [DATA_W-1:0] REQ_MASK;
    logic              RSP_VALID;
    logic [DATA_W-1:0] RSP_RDATA;
    logic              RSP_ERR;
    logic [CTRL_W-1:0] DRI_CTRL;
    logic [DATA_W-1:0] DRI_WDATA;
    logic              DRI_ARST_N;
    logic [DATA_W-1:0] DRI_RDATA;
    logic              DRI_INTERRUPT;
    logic              PLL_LOCK;

    modport master (
        input  REQ_VALID, REQ_OP, REQ_ADDR, REQ_WDATA, REQ_MASK, DRI_RDATA, DRI_INTERRUPT,
`ifdef PLL_DRI_RELOCK_WAIT_EN
        input  PLL_LOCK,
`endif
        output REQ_READY, RSP_VALID, RSP_RDATA, RSP_ERR, DRI_CTRL, DRI_WDATA, DRI_ARST_N
    );

    modport slave (
        output REQ_VALID, REQ_OP, REQ_ADDR, REQ_WDATA, REQ_MASK, DRI_RDATA, DRI_INTERRUPT,
        output PLL_LOCK,
        input  REQ_READY, RSP_VALID, RSP_RDATA, RSP_ERR, DRI_CTRL, DRI_WDATA, DRI_ARST_N
    );

endinterface

// File: rtl/pll_dri_timeout.sv
// Purpose: 8-bit saturating wait counter; expired flags the last permitted wait cycle.
// Latency: clear/increment take effect at the next edge; expired is combinational.
// Backpressure: none.
module pll_dri_timeout #(
    parameter logic [7:0] LIMIT = 8'd255
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    logic [7:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && (cnt != 8'hFF)) begin
            cnt <= cnt + 8'd1;
        end
    end

    // True in the wait cycle whose increment would bring the count to LIMIT
    assign expired = en && (cnt >= (LIMIT - 8'd1));

endmodule

// File: rtl/pll_dri_master.sv
// Purpose: sequences read/write/RMW requests onto the PF_CCC DRI; macro PLL_DRI_RELOCK_WAIT_EN adds a relock wait.
// Latency: read = interrupt wait cycle k + 2; RMW = both phases; 255-cycle timeout per wait.
// Backpressure: one request in flight, REQ_READY only in IDLE; response is an unthrottled pulse.
module pll_dri_master
    import pll_dri_pkg::*;
#(
    parameter int TIMEOUT     = 255,
    parameter int ARST_CYCLES = 4
) (
    input logic              CLK,
    input logic              RESET,
    pll_dri_master_if.master bus
);

    localparam logic [7:0] INIT_LAST = 8'(ARST_CYCLES - 1);

    state_e            state;
    logic [7:0]        init_cnt;
    logic              rmw;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] mask_q;
    logic [DATA_W-1:0] merged;
    logic              tmo_clr;
    logic              tmo_en;
    logic              tmo_exp;

    assign merged = (bus.DRI_RDATA & ~mask_q) | (wdata_q & mask_q);
    assign tmo_en = state inside {ST_RD_WAIT, ST_WR_WAIT, ST_RELOCK};

`ifdef PLL_DRI_RELOCK_WAIT_EN
    logic [1:0] lock_sync;
    logic       lock_s;
    logic       lock_fell;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) lock_sync <= '0;
        else       lock_sync <= {lock_sync[0], bus.PLL_LOCK};
    end
    assign lock_s  = lock_sync[1];
    assign tmo_clr = (state == ST_RD_ISSUE) || (state == ST_WR_ISSUE) ||
                     ((state == ST_WR_WAIT) && bus.DRI_INTERRUPT);
`else
    assign tmo_clr = (state == ST_RD_ISSUE) || (state == ST_WR_ISSUE);
`endif

    pll_dri_timeout #(.LIMIT(8'(TIMEOUT))) u_timeout (
        .clk     (CLK),
        .rst     (RESET),
        .clr     (tmo_clr),
        .en      (tmo_en),
        .expired (tmo_exp)
    );

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state          <= ST_INIT;
            init_cnt       <= '0;
            rmw            <= 1'b0;
            addr_q         <= '0;
            wdata_q        <= '0;
            mask_q         <= '0;
            bus.REQ_READY  <= 1'b0;
            bus.RSP_VALID  <= 1'b0;
            bus.RSP_RDATA  <= '0;
            bus.RSP_ERR    <= 1'b0;
            bus.DRI_CTRL   <= '0;
            bus.DRI_WDATA  <= '0;
            bus.DRI_ARST_N <= 1'b0;
`ifdef PLL_DRI_RELOCK_WAIT_EN
            lock_fell      <= 1'b0;
`endif
        end else begin
            case (state)
                ST_INIT: begin
                    if (init_cnt == INIT_LAST) begin
                        bus.DRI_ARST_N <= 1'b1;
                        bus.REQ_READY  <= 1'b1;
                        state          <= ST_IDLE;
                    end else begin
                        init_cnt <= init_cnt + 8'd1;
                    end
                end
                ST_IDLE: begin
                    if (bus.REQ_VALID) begin
                        bus.REQ_READY <= 1'b0;
                        bus.RSP_ERR   <= 1'b0;
                        addr_q        <= bus.REQ_ADDR;
                        wdata_q       <= bus.REQ_WDATA;
                        mask_q        <= bus.REQ_MASK;
                        rmw           <= (bus.REQ_OP == OP_RMW);
                        // Issue-cycle CTRL is loaded here so it is valid for exactly the ISSUE state
                        if (bus.REQ_OP == OP_WR) begin
                            bus.DRI_CTRL  <= dri_ctrl(1'b1, 1'b0, bus.REQ_ADDR);
                            bus.DRI_WDATA <= bus.REQ_WDATA;
                            state         <= ST_WR_ISSUE;
                        end else begin
                            bus.DRI_CTRL <= dri_ctrl(1'b0, 1'b1, bus.REQ_ADDR);
                            state        <= ST_RD_ISSUE;
                        end
                    end
                end
                ST_RD_ISSUE: begin
                    bus.DRI_CTRL <= '0;
                    state        <= ST_RD_WAIT;
                end
                ST_RD_WAIT: begin
                    if (bus.DRI_INTERRUPT) begin
                        bus.RSP_RDATA <= bus.DRI_RDATA;
                        if (rmw) begin
                            bus.DRI_CTRL  <= dri_ctrl(1'b1, 1'b0, addr_q);
                            bus.DRI_WDATA <= merged;
                            state         <= ST_WR_ISSUE;
                        end else begin
                            bus.RSP_VALID <= 1'b1;
                            state         <= ST_RESP;
                        end
                    end else if (tmo_exp) begin
                        bus.RSP_ERR   <= 1'b1;
                        bus.RSP_VALID <= 1'b1;
                        state         <= ST_RESP;
                    end
                end
                ST_WR_ISSUE: begin
                    bus.DRI_CTRL <= '0;
                    state        <= ST_WR_WAIT;
                end
                ST_WR_WAIT: begin
                    if (bus.DRI_INTERRUPT) begin
`ifdef PLL_DRI_RELOCK_WAIT_EN
                        lock_fell <= ~lock_s;
                        state     <= ST_RELOCK;
`else
                        bus.RSP_VALID <= 1'b1;
                        state         <= ST_RESP;
`endif
                    end else if (tmo_exp) begin
                        bus.RSP_ERR   <= 1'b1;
                        bus.RSP_VALID <= 1'b1;
                        state         <= ST_RESP;
                    end
                end
`ifdef PLL_DRI_RELOCK_WAIT_EN
                ST_RELOCK: begin
                    if (lock_fell && lock_s) begin
                        bus.RSP_VALID <= 1'b1;
                        state         <= ST_RESP;
                    end else if (tmo_exp) begin
                        bus.RSP_ERR   <= 1'b1;
                        bus.RSP_VALID <= 1'b1;
                        state         <= ST_RESP;
                    end else if (!lock_s) begin
                        lock_fell <= 1'b1;
                    end
                end
`endif
                ST_RESP: begin
                    bus.RSP_VALID <= 1'b0;
                    bus.REQ_READY <= 1'b1;
                    state         <= ST_IDLE;
                end
                default: begin
                    bus.REQ_READY <= 1'b1;
                    state         <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pll_dri_master.sv
// Directed bench for pll_dri_master; the PLL side of DRI is driven step by step.
module tb_pll_dri_master;
    import pll_dri_pkg::*;

    logic CLK   = 1'b0;
    logic RESET = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;
    logic seen;
    logic errv;

    pll_dri_master_if bus();

    pll_dri_master #(.TIMEOUT(255), .ARST_CYCLES(4)) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus)
    );

    always #5 CLK = ~CLK;

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bus.REQ_VALID     = 1'b0;
        bus.REQ_OP        = OP_RD;
        bus.REQ_ADDR      = '0;
        bus.REQ_WDATA     = '0;
        bus.REQ_MASK      = '0;
        bus.DRI_RDATA     = '0;
        bus.DRI_INTERRUPT = 1'b0;
        bus.PLL_LOCK      = 1'b1;
        seen              = 1'b0;
        errv              = 1'b0;

        // Reset values
        RESET = 1'b1;
        tick;
        tick;
        check("rst_ready",   64'(bus.REQ_READY),  64'd0);
        check("rst_rsp_vld", 64'(bus.RSP_VALID),  64'd0);
        check("rst_rdata",   64'(bus.RSP_RDATA),  64'd0);
        check("rst_err",     64'(bus.RSP_ERR),    64'd0);
        check("rst_ctrl",    64'(bus.DRI_CTRL),   64'd0);
        check("rst_wdata",   64'(bus.DRI_WDATA),  64'd0);
        check("rst_arst_n",  64'(bus.DRI_ARST_N), 64'd0);

        // INIT: DRI_ARST_N low for 4 cycles after release, READY rises with it
        RESET = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            tick;
            check("init_arst_low", 64'(bus.DRI_ARST_N), 64'd0);
            check("init_not_rdy",  64'(bus.REQ_READY),  64'd0);
        end
        tick;
        check("init_arst_high", 64'(bus.DRI_ARST_N), 64'd1);
        check("init_ready",     64'(bus.REQ_READY),  64'd1);

        // Read 0x005, interrupt in wait cycle 3
        bus.REQ_OP    = OP_RD;
        bus.REQ_ADDR  = REG_DIV0_CTRL;
        bus.REQ_VALID = 1'b1;
        tick;
        bus.REQ_VALID = 1'b0;
        check("rd_ctrl_issue", 64'(bus.DRI_CTRL),  64'h205);
        check("rd_busy",       64'(bus.REQ_READY), 64'd0);
        tick;
        check("rd_ctrl_wait", 64'(bus.DRI_CTRL), 64'h000);
        tick;
        tick;
        bus.DRI_INTERRUPT = 1'b1;
        bus.DRI_RDATA     = 33'h1_2345_6789;
        check("rd_no_early_rsp", 64'(bus.RSP_VALID), 64'd0);
        tick;
        bus.DRI_INTERRUPT = 1'b0;
        check("rd_rsp_vld",   64'(bus.RSP_VALID), 64'd1);
        check("rd_rsp_rdata", 64'(bus.RSP_RDATA), 64'h1_2345_6789);
        check("rd_rsp_err",   64'(bus.RSP_ERR),   64'd0);
        tick;
        check("rd_rsp_pulse", 64'(bus.RSP_VALID), 64'd0);
        check("rd_ready_back", 64'(bus.REQ_READY), 64'd1);

        // RMW: FF00 with low byte replaced by 7F
        bus.REQ_OP    = OP_RMW;
        bus.REQ_ADDR  = REG_DIV0_CTRL;
        bus.REQ_WDATA = 33'h0_0000_007F;
        bus.REQ_MASK  = 33'h0_0000_00FF;
        bus.REQ_VALID = 1'b1;
        tick;
        bus.REQ_VALID = 1'b0;
        check("rmw_rd_ctrl", 64'(bus.DRI_CTRL), 64'h205);
        tick;
        bus.DRI_INTERRUPT = 1'b1;
        bus.DRI_RDATA     = 33'h0_0000_FF00;
        tick;
        bus.DRI_INTERRUPT = 1'b0;
        check("rmw_wr_ctrl",  64'(bus.DRI_CTRL),  64'h405);
        check("rmw_wr_data",  64'(bus.DRI_WDATA), 64'hFF7F);
        check("rmw_mid_vld",  64'(bus.RSP_VALID), 64'd0);
        tick;
        check("rmw_wr_ctrl_clr", 64'(bus.DRI_CTRL), 64'h000);
        bus.DRI_INTERRUPT = 1'b1;
        tick;
        bus.DRI_INTERRUPT = 1'b0;
`ifdef PLL_DRI_RELOCK_WAIT_EN
        check("relock_hold", 64'(bus.RSP_VALID), 64'd0);
        bus.PLL_LOCK = 1'b0;
        seen = 1'b0;
        repeat (10) begin
            tick;
            if (bus.RSP_VALID) seen = 1'b1;
        end
        check("relock_early", 64'(seen), 64'd0);
        bus.PLL_LOCK = 1'b1;
        tick;
        tick;
        check("relock_sync", 64'(bus.RSP_VALID), 64'd0);
        tick;
`endif
        check("rmw_rsp_vld",   64'(bus.RSP_VALID), 64'd1);
        check("rmw_rsp_rdata", 64'(bus.RSP_RDATA), 64'hFF00);
        check("rmw_rsp_err",   64'(bus.RSP_ERR),   64'd0);
        tick;

        // Write with no interrupt: error after 255 wait cycles
        bus.REQ_OP    = OP_WR;
        bus.REQ_ADDR  = 9'h010;
        bus.REQ_WDATA = 33'h1_0000_0001;
        bus.REQ_VALID = 1'b1;
        tick;
        bus.REQ_VALID = 1'b0;
        check("wr_ctrl_issue", 64'(bus.DRI_CTRL),  64'h410);
        check("wr_wdata",      64'(bus.DRI_WDATA), 64'h1_0000_0001);
        seen = 1'b0;
        for (int i = 0; i < 254; i++) begin
            tick;
            if (bus.RSP_VALID) seen = 1'b1;
        end
        tick;
        check("tmo_not_early", 64'(seen | bus.RSP_VALID), 64'd0);
        tick;
        check("tmo_rsp_vld", 64'(bus.RSP_VALID), 64'd1);
        check("tmo_rsp_err", 64'(bus.RSP_ERR),   64'd1);
        tick;
        check("tmo_err_held", 64'(bus.RSP_ERR), 64'd1);

        // Next read clears the error on acceptance and succeeds
        bus.REQ_OP    = OP_RD;
        bus.REQ_ADDR  = REG_DIV1_CTRL;
        bus.REQ_VALID = 1'b1;
        tick;
        bus.REQ_VALID = 1'b0;
        check("err_clr_accept", 64'(bus.RSP_ERR),  64'd0);
        check("rd2_ctrl",       64'(bus.DRI_CTRL), 64'h206);
        tick;
        bus.DRI_INTERRUPT = 1'b1;
        bus.DRI_RDATA     = 33'h1_FFFF_0000;
        tick;
        bus.DRI_INTERRUPT = 1'b0;
        check("rd2_rsp_vld",   64'(bus.RSP_VALID), 64'd1);
        check("rd2_rsp_rdata", 64'(bus.RSP_RDATA), 64'h1_FFFF_0000);
        check("rd2_rsp_err",   64'(bus.RSP_ERR),   64'd0);
        tick;

        // Reset in RD_WAIT aborts without a response
        bus.REQ_OP    = OP_RD;
        bus.REQ_ADDR  = REG_DIV0_CTRL;
        bus.REQ_VALID = 1'b1;
        tick;
        bus.REQ_VALID = 1'b0;
        tick;
        RESET = 1'b1;
        #1;
        check("abort_ctrl",   64'(bus.DRI_CTRL),   64'd0);
        check("abort_arst_n", 64'(bus.DRI_ARST_N), 64'd0);
        bus.DRI_INTERRUPT = 1'b1;
        tick;
        tick;
        check("abort_no_rsp", 64'(bus.RSP_VALID), 64'd0);
        RESET = 1'b0;
        bus.DRI_INTERRUPT = 1'b0;
        seen = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            tick;
            if (bus.RSP_VALID) seen = 1'b1;
            check("reinit_arst_low", 64'(bus.DRI_ARST_N), 64'd0);
        end
        tick;
        check("reinit_no_rsp", 64'(seen | bus.RSP_VALID), 64'd0);
        check("reinit_arst_high", 64'(bus.DRI_ARST_N), 64'd1);
        check("reinit_ready",     64'(bus.REQ_READY),  64'd1);

`ifdef PLL_DRI_RELOCK_WAIT_EN
        // Lock never returns after a write: relock times out
        bus.REQ_OP    = OP_WR;
        bus.REQ_ADDR  = 9'h011;
        bus.REQ_VALID = 1'b1;
        tick;
        bus.REQ_VALID = 1'b0;
        tick;
        bus.DRI_INTERRUPT = 1'b1;
        bus.PLL_LOCK      = 1'b0;
        tick;
        bus.DRI_INTERRUPT = 1'b0;
        seen = 1'b0;
        errv = 1'b0;
        for (int i = 0; i < 300 && !seen; i++) begin
            tick;
            if (bus.RSP_VALID) begin
                seen = 1'b1;
                errv = bus.RSP_ERR;
            end
        end
        check("stuck_rsp_vld", 64'(seen), 64'd1);
        check("stuck_rsp_err", 64'(errv), 64'd1);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
